udp_tx_pkt_queue: RTL and testbench

//  Single-clock packet queue feeding the UDP transmit engine. Accepts 32-bit words from a packet

---
 rtl/udp_q_pkg.sv | 20 ++
 rtl/udp_pkt_ram.sv | 34 +++
 rtl/udp_tx_pkt_queue.sv | 239 +++++++++++++++++++++++
 tb/tb_udp_tx_pkt_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_q_pkg.sv
// Shared types and helpers for the UDP transmit packet queue.
package udp_q_pkg;

    // Largest payload the queue accepts by default, in bytes.
    localparam int DEF_MAX_BYTES = 1472;

    // Read-side FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_GAP
    } tx_state_e;

    // Number of 32-bit words needed to carry a byte count (rounded up).
    function automatic logic [15:0] words_of(input logic [15:0] bytes);
        return 16'(({1'b0, bytes} + 17'd3) >> 2);
    endfunction

endpackage

// File: rtl/udp_pkt_ram.sv
// Simple dual-port 32-bit payload RAM with a registered read port (1-cycle latency).
// The read register holds its value when no read is issued.
module udp_pkt_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [2**AW];

    // Write port: store a payload word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, cleared by reset so the engine sees zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_tx_pkt_queue.sv
// Packet queue in front of the UDP transmit engine: stores whole packets,
// drops bad or overflowing ones, and replays committed packets one at a time.
//
// Handshakes: the source has no backpressure; every cycle with in_valid=1
// delivers one word, and in_last (qualified by in_valid) closes the packet,
// with in_byte_num sampled on that same cycle. On the engine side,
// tx_start_en pulses for one cycle per packet, each tx_req accepted in SEND
// yields tx_data on the following cycle, and tx_pkg_done ends the packet.
module udp_tx_pkt_queue
    import udp_q_pkg::*;
#(
    parameter int DATA_AW    = 10,
    parameter int LEN_AW     = 4,
    parameter int MAX_BYTES  = DEF_MAX_BYTES,
    parameter int IFG_CYCLES = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    input  logic [15:0]       in_byte_num,
    output logic              tx_start_en,
    output logic [15:0]       tx_byte_num,
    input  logic              tx_req,
    output logic [31:0]       tx_data,
    input  logic              tx_pkg_done,
    output logic [LEN_AW:0]   pkt_pending,
    output logic [15:0]       drop_cnt
);

    localparam int PW = DATA_AW + 1;
    localparam logic [PW-1:0]     DEPTH     = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [LEN_AW:0]   LQ_DEPTH  = {1'b1, {LEN_AW{1'b0}}};
    localparam logic [15:0]       MAX_WORDS = words_of(16'(MAX_BYTES));
    localparam logic [7:0]        IFG_LOAD  = 8'(IFG_CYCLES);

    // Data RAM pointers: one extra MSB so full and empty are distinguishable.
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      cmt_ptr;
    logic [PW-1:0]      rel_ptr;
    logic [PW-1:0]      pkt_end;
    logic [DATA_AW-1:0] rd_ptr;
    logic [PW-1:0]      used;
    logic [PW-1:0]      cur_words;
    logic               pkt_bad;
    logic               word_ok;
    logic               ram_we;
    logic               commit_ok;

    // Length queue.
    logic [15:0]        len_mem [2**LEN_AW];
    logic [LEN_AW:0]    lq_wr;
    logic [LEN_AW:0]    lq_rd;
    logic [LEN_AW:0]    lq_count;
    logic               lq_full;
    logic               lq_empty;
    logic               lq_pop;
    logic [15:0]        pop_len;
    logic [15:0]        pop_words;

    // Read side.
    tx_state_e          state;
    tx_state_e          state_next;
    logic [15:0]        word_left;
    logic [7:0]         gap_cnt;
    logic               rd_en;
    logic               zero_req;
    logic               zero_f;
    logic [31:0]        ram_rd_data;

    assign used      = wr_ptr - rel_ptr;
    assign cur_words = wr_ptr - cmt_ptr;
    // A word fits only if the RAM has room and the packet is under the size cap.
    assign word_ok   = (used != DEPTH) && (16'(cur_words) < MAX_WORDS);
    assign ram_we    = in_valid && word_ok && !pkt_bad;

    assign lq_count  = lq_wr - lq_rd;
    assign lq_full   = (lq_count == LQ_DEPTH);
    assign lq_empty  = (lq_count == '0);
    assign pkt_pending = lq_count;

    // The closing word commits only if every word so far was stored and the
    // declared length is legal and agrees with the stored word count.
    assign commit_ok = in_valid && in_last && !pkt_bad && word_ok &&
                       (in_byte_num != 16'd0) && (in_byte_num <= 16'(MAX_BYTES)) &&
                       (words_of(in_byte_num) == 16'(cur_words) + 16'd1) && !lq_full;

    assign pop_len   = len_mem[lq_rd[LEN_AW-1:0]];
    assign pop_words = words_of(pop_len);

    assign tx_start_en = (state == ST_START);
    assign tx_data     = zero_f ? 32'd0 : ram_rd_data;

    udp_pkt_ram #(
        .AW (DATA_AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr[DATA_AW-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // Write side: advance per stored word, commit or rewind at the closing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            pkt_bad  <= 1'b0;
            drop_cnt <= '0;
        end else if (in_valid) begin
            if (in_last) begin
                pkt_bad <= 1'b0;
                if (commit_ok) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    cmt_ptr <= wr_ptr + 1'b1;
                end else begin
                    wr_ptr <= cmt_ptr;
                    if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
            end else if (ram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end else begin
                pkt_bad <= 1'b1;
            end
        end
    end

    // Length queue storage: one entry per committed packet.
    always_ff @(posedge clk) begin
        if (commit_ok) begin
            len_mem[lq_wr[LEN_AW-1:0]] <= in_byte_num;
        end
    end

    // Length queue pointers: push on commit, pop when the FSM starts a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq_wr <= '0;
            lq_rd <= '0;
        end else begin
            if (commit_ok) begin
                lq_wr <= lq_wr + 1'b1;
            end
            if (lq_pop) begin
                lq_rd <= lq_rd + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_next = state;
        lq_pop     = 1'b0;
        rd_en      = 1'b0;
        zero_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!lq_empty) begin
                    lq_pop     = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_req) begin
                    if (word_left != 16'd0) begin
                        rd_en = 1'b1;
                    end else begin
                        zero_req = 1'b1;
                    end
                end
                if (tx_pkg_done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read datapath: packet setup on pop, word streaming, release and gap timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_num <= '0;
            rd_ptr      <= '0;
            pkt_end     <= '0;
            word_left   <= '0;
            rel_ptr     <= '0;
            gap_cnt     <= '0;
            zero_f      <= 1'b0;
        end else begin
            if (lq_pop) begin
                tx_byte_num <= pop_len;
                rd_ptr      <= rel_ptr[DATA_AW-1:0];
                pkt_end     <= rel_ptr + PW'(pop_words);
                word_left   <= pop_words;
            end
            if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                word_left <= word_left - 16'd1;
                zero_f    <= 1'b0;
            end else if (zero_req) begin
                zero_f <= 1'b1;
            end
            // Release the whole packet regardless of how many words were read.
            if (state == ST_SEND && tx_pkg_done) begin
                rel_ptr <= pkt_end;
                gap_cnt <= IFG_LOAD;
            end else if (state == ST_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_pkt_queue.sv
// Self-checking bench for udp_tx_pkt_queue: a packet driver, an engine model
// that checks start/length/data against a scoreboard, and directed scenarios.
module tb_udp_tx_pkt_queue;

    localparam int IFG = 12;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [15:0] in_byte_num;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_pkg_done;
    logic [4:0]  pkt_pending;
    logic [15:0] drop_cnt;

    // Scoreboard state.
    logic [31:0] exp_q[$];
    logic [15:0] exp_len_q[$];
    logic [31:0] pat_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          starts = 0;
    int          exp_drop = 0;
    int          extra_req = 0;
    bit          hold_done = 0;
    bit          abort_eng = 0;
    bit          eng_busy = 0;

    udp_tx_pkt_queue #(
        .DATA_AW    (10),
        .LEN_AW     (4),
        .MAX_BYTES  (1472),
        .IFG_CYCLES (IFG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_byte_num (in_byte_num),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_pkg_done (tx_pkg_done),
        .pkt_pending (pkt_pending),
        .drop_cnt    (drop_cnt)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int bw(input int bytes);
        return (bytes + 3) / 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver: one packet, back-to-back words; expected data queued only if it should commit.
    task automatic send_pkt(input int bytes, input int nw, input bit ok);
        logic [31:0] w;
        if (ok) exp_len_q.push_back(16'(bytes));
        for (int i = 0; i < nw; i++) begin
            if (pat_q.size() != 0) w = pat_q.pop_front();
            else w = $urandom();
            if (ok) exp_q.push_back(w);
            in_valid    = 1'b1;
            in_data     = w;
            in_last     = (i == nw - 1);
            in_byte_num = 16'(bytes);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) exp_drop++;
    endtask

    task automatic wait_drained(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0 || eng_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        repeat (IFG + 4) @(negedge clk);
    endtask

    // Engine model: checks the start pulse, length and every requested word.
    initial begin : engine
        int nw;
        int words;
        logic [15:0] exp_len;
        tx_req = 1'b0;
        tx_pkg_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start_en) begin
                eng_busy = 1'b1;
                starts++;
                if (exp_len_q.size() == 0) begin
                    check("unexpected_start", 32'(tx_byte_num), 32'hFFFF_FFFF);
                    words = bw(int'(tx_byte_num));
                end else begin
                    exp_len = exp_len_q.pop_front();
                    check("tx_byte_num", 32'(tx_byte_num), 32'(exp_len));
                    words = bw(int'(exp_len));
                end
                @(negedge clk);
                check("start_pulse_width", 32'(tx_start_en), 32'd0);
                nw = words + extra_req;
                if (nw < 0) nw = 0;
                for (int i = 0; i < nw; i++) begin
                    tx_req = 1'b1;
                    @(negedge clk);
                    tx_req = 1'b0;
                    if (i < words) begin
                        if (exp_q.size() == 0) check("data_underflow", 32'd0, 32'd1);
                        else check("tx_data", tx_data, exp_q.pop_front());
                    end else begin
                        check("tx_data_tail_zero", tx_data, 32'd0);
                    end
                end
                for (int i = nw; i < words; i++) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                while (hold_done && !abort_eng) @(negedge clk);
                if (!abort_eng) begin
                    tx_pkg_done = 1'b1;
                    @(negedge clk);
                    tx_pkg_done = 1'b0;
                end
                eng_busy = 1'b0;
            end
        end
    end

    // Main sequence.
    initial begin
        int s0;
        int n;
        int bad_bytes [4] = '{0, 1473, 4, 8};
        int bad_words [4] = '{1, 369, 2, 1};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        in_byte_num = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_pkt_pending", 32'(pkt_pending), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) basic 8-byte packet
        s0 = starts;
        pat_q = '{32'h01020304, 32'h05060708};
        send_pkt(8, 2, 1'b1);
        wait_drained(300);
        check("t1_start_count", 32'(starts - s0), 32'd1);

        // 2) length mismatch and other illegal packets, then a good one
        s0 = starts;
        send_pkt(9, 2, 1'b0);
        check("t2_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        repeat (30) @(negedge clk);
        check("t2_no_start", 32'(starts - s0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_pkt(bad_bytes[i], bad_words[i], 1'b0);
            check("bad_pkt_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        end
        send_pkt(12, 3, 1'b1);
        wait_drained(300);

        // random good packets
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(1, 64);
            send_pkt(n, bw(n), 1'b1);
        end
        wait_drained(3000);

        // 5) extra request returns zero; short read still realigns the next packet
        extra_req = 1;
        send_pkt(8, 2, 1'b1);
        wait_drained(300);
        extra_req = -1;
        send_pkt(8, 2, 1'b1);
        wait_drained(300);
        extra_req = 0;
        send_pkt(12, 3, 1'b1);
        wait_drained(300);

        // 3) length queue overflow: one packet in flight plus 16 queued, next dropped
        hold_done = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send_pkt(4, 1, i < 17);
        end
        check("t3_pkt_pending_full", 32'(pkt_pending), 32'd16);
        check("t3_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        hold_done = 1'b0;
        wait_drained(3000);
        check("t3_pkt_pending_empty", 32'(pkt_pending), 32'd0);

        // 4) fill 1020 words, extra packet overflows on its 5th word
        hold_done = 1'b1;
        send_pkt(1472, 368, 1'b1);
        send_pkt(1472, 368, 1'b1);
        send_pkt(1136, 284, 1'b1);
        send_pkt(32, 8, 1'b0);
        check("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("t4_pkt_pending", 32'(pkt_pending), 32'd2);
        hold_done = 1'b0;
        wait_drained(6000);
        n = $urandom_range(20, 60);
        send_pkt(n, bw(n), 1'b1);
        wait_drained(500);

        // 6) reset during SEND
        hold_done = 1'b1;
        pat_q = '{32'hA5A5_0001, 32'h5A5A_0002};
        send_pkt(8, 2, 1'b1);
        n = 0;
        while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_reads_in_budget", 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
        abort_eng = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("t6_rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("t6_rst_tx_data", tx_data, 32'd0);
        check("t6_rst_pkt_pending", 32'(pkt_pending), 32'd0);
        check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (3) @(negedge clk);
        hold_done = 1'b0;
        n = 0;
        while (eng_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        abort_eng = 1'b0;
        rst_n = 1'b1;
        s0 = starts;
        repeat (40) @(negedge clk);
        check("t6_no_start_after_reset", 32'(starts - s0), 32'd0);
        check("t6_pkt_pending_after", 32'(pkt_pending), 32'd0);
        check("t6_tx_data_after", tx_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
